// File: rtl/utm_pkg.sv
// rtl/utm_pkg.sv - shared types, widths and helpers for the UTM step controller
package utm_pkg;

    localparam int SYM_W   = 3;
    localparam int STATE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } fsm_t;

    localparam logic [1:0] FLT_NONE  = 2'd0;
    localparam logic [1:0] FLT_LEFT  = 2'd1;
    localparam logic [1:0] FLT_RIGHT = 2'd2;
    localparam logic [1:0] FLT_STATE = 2'd3;

    function automatic logic is_onehot(input logic [STATE_W-1:0] s);
        return (s != '0) && ((s & (s - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/utm_tape.sv
// rtl/utm_tape.sv - tape register file, one synchronous write port, two combinational reads
module utm_tape
    import utm_pkg::*;
#(
    parameter int TAPE_LEN = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SYM_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] head_addr,
    output logic [SYM_W-1:0]  head_sym,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [SYM_W-1:0]  rd_sym
);

    // Contents are deliberately left unreset so a reset mid-run preserves the tape.
    logic [SYM_W-1:0] mem [TAPE_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign head_sym = mem[head_addr];
    assign rd_sym   = mem[rd_addr];

endmodule

// File: rtl/utm_step_controller.sv
// rtl/utm_step_controller.sv - sequences one Turing-machine step per READ/EVAL/WRITE pass
module utm_step_controller
    import utm_pkg::*;
#(
    parameter int                 TAPE_LEN   = 32,
    parameter int                 ADDR_W     = 5,
    parameter int                 START_HEAD = 0,
    parameter logic [STATE_W-1:0] INIT_STATE = 8'b0000_0001,
    parameter int                 MAX_STEPS  = 1023,
    parameter int                 CNT_W      = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [SYM_W-1:0]   load_sym,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [SYM_W-1:0]   rd_sym,
    output logic [STATE_W-1:0] rule_state,
    output logic [SYM_W-1:0]   rule_sym,
    input  logic [SYM_W-1:0]   rule_new_sym,
    input  logic [STATE_W-1:0] rule_next_state,
    input  logic               rule_move_right,
    output logic               busy,
    output logic               done,
    output logic [1:0]         fault,
    output logic               timeout,
    output logic [ADDR_W-1:0]  head_pos,
    output logic [CNT_W-1:0]   step_count
);

    localparam logic [ADDR_W-1:0] HEAD_LAST = ADDR_W'(TAPE_LEN - 1);
    localparam logic [ADDR_W-1:0] HEAD_INIT = ADDR_W'(START_HEAD);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_STEPS);

    fsm_t               state, state_nxt;
    logic [STATE_W-1:0] ns;
    logic [SYM_W-1:0]   nsym;
    logic               mv;
    logic [SYM_W-1:0]   head_sym;
    logic               ns_halt, ns_bad, edge_fault, step_wr;
    logic [CNT_W-1:0]   count_inc;
    logic               tape_we;
    logic [ADDR_W-1:0]  tape_waddr;
    logic [SYM_W-1:0]   tape_wdata;

    assign ns_halt    = (ns == '0);
    assign ns_bad     = !ns_halt && !is_onehot(ns);
    assign edge_fault = !ns_halt && !ns_bad &&
                        (mv ? (head_pos == HEAD_LAST) : (head_pos == '0));
    assign count_inc  = (step_count == CNT_MAX) ? step_count : step_count + 1'b1;

    assign busy = (state == ST_READ) || (state == ST_EVAL) || (state == ST_WRITE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_wr   = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_READ;
            ST_READ:          state_nxt = ST_EVAL;
            ST_EVAL:          state_nxt = ST_WRITE;
            ST_WRITE: begin
                step_wr = !ns_bad;
                if (ns_halt || ns_bad || edge_fault || count_inc == CNT_MAX) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_READ;
                end
            end
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Step writes only occur while busy, so they never collide with a host load.
    assign tape_we    = step_wr || (load_en && !busy);
    assign tape_waddr = step_wr ? head_pos : load_addr;
    assign tape_wdata = step_wr ? nsym : load_sym;

    utm_tape #(
        .TAPE_LEN (TAPE_LEN),
        .ADDR_W   (ADDR_W)
    ) u_tape (
        .clk       (clk),
        .we        (tape_we),
        .waddr     (tape_waddr),
        .wdata     (tape_wdata),
        .head_addr (head_pos),
        .head_sym  (head_sym),
        .rd_addr   (rd_addr),
        .rd_sym    (rd_sym)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rule_state <= '0;
            rule_sym   <= '0;
            head_pos   <= '0;
            step_count <= '0;
            fault      <= FLT_NONE;
            timeout    <= 1'b0;
            ns         <= '0;
            nsym       <= '0;
            mv         <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        head_pos   <= HEAD_INIT;
                        rule_state <= INIT_STATE;
                        step_count <= '0;
                        fault      <= FLT_NONE;
                        timeout    <= 1'b0;
                    end
                end
                ST_READ: rule_sym <= head_sym;
                ST_EVAL: begin
                    ns   <= rule_next_state;
                    nsym <= rule_new_sym;
                    mv   <= rule_move_right;
                end
                ST_WRITE: begin
                    if (ns_halt) begin
                        step_count <= count_inc;
                    end else if (ns_bad) begin
                        fault <= FLT_STATE;
                    end else begin
                        rule_state <= ns;
                        step_count <= count_inc;
                        if (edge_fault) begin
                            fault <= mv ? FLT_RIGHT : FLT_LEFT;
                        end else begin
                            head_pos <= mv ? head_pos + 1'b1 : head_pos - 1'b1;
                            if (count_inc == CNT_MAX) timeout <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_utm_step_controller.sv
// tb/tb_utm_step_controller.sv - randomized and directed bench against a step-level machine model
module tb_utm_step_controller;

    localparam int TL = 8;
    localparam int AW = 3;
    localparam int MS = 8;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, load_en;
    logic [AW-1:0] load_addr, rd_addr;
    logic [2:0]    load_sym, rd_sym, rule_sym, rule_new_sym;
    logic [7:0]    rule_state, rule_next_state;
    logic          rule_move_right, busy, done, timeout;
    logic [1:0]    fault;
    logic [AW-1:0] head_pos;
    logic [CW-1:0] step_count;

    utm_step_controller #(
        .TAPE_LEN(TL), .ADDR_W(AW), .START_HEAD(0), .INIT_STATE(8'h01),
        .MAX_STEPS(MS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_sym(load_sym), .rd_addr(rd_addr), .rd_sym(rd_sym),
        .rule_state(rule_state), .rule_sym(rule_sym), .rule_new_sym(rule_new_sym),
        .rule_next_state(rule_next_state), .rule_move_right(rule_move_right),
        .busy(busy), .done(done), .fault(fault), .timeout(timeout),
        .head_pos(head_pos), .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Rule tables indexed by (one-hot state position, symbol under head).
    logic [2:0] tab_nsym [8][8];
    logic [7:0] tab_ns   [8][8];
    logic       tab_mv   [8][8];

    function automatic int sidx(input logic [7:0] s);
        for (int i = 0; i < 8; i++) if (s[i]) return i;
        return 0;
    endfunction

    always_comb begin
        rule_new_sym    = tab_nsym[sidx(rule_state)][rule_sym];
        rule_next_state = tab_ns[sidx(rule_state)][rule_sym];
        rule_move_right = tab_mv[sidx(rule_state)][rule_sym];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [2:0] tape_m [TL];
    logic [2:0] m_tape [TL];
    int         m_head, m_cnt, m_flt, m_to, m_act, last_cycles;
    logic [7:0] m_state;

    task automatic set_all(input int idx, input logic [2:0] nsym, input logic [7:0] ns, input logic mv);
        for (int j = 0; j < 8; j++) begin
            tab_nsym[idx][j] = nsym;
            tab_ns[idx][j]   = ns;
            tab_mv[idx][j]   = mv;
        end
    endtask

    task automatic randomize_tables();
        int r;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                r = $urandom_range(0, 99);
                if (r < 15)      tab_ns[i][j] = 8'h00;
                else if (r < 22) tab_ns[i][j] = 8'h03 << $urandom_range(0, 6);
                else             tab_ns[i][j] = 8'h01 << $urandom_range(0, 7);
                tab_nsym[i][j] = 3'($urandom_range(0, 7));
                tab_mv[i][j]   = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic load_cell(input int a, input logic [2:0] s);
        load_en = 1'b1; load_addr = AW'(a); load_sym = s;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic load_tape();
        for (int i = 0; i < TL; i++) load_cell(i, tape_m[i]);
    endtask

    // Machine interpreter: applies the transition rules cell by cell until the run ends.
    task automatic model();
        logic [2:0] nsym;
        logic [7:0] ns;
        logic       mv;
        for (int i = 0; i < TL; i++) m_tape[i] = tape_m[i];
        m_head = 0; m_state = 8'h01; m_cnt = 0; m_flt = 0; m_to = 0; m_act = 0;
        forever begin
            m_act++;
            nsym = tab_nsym[sidx(m_state)][m_tape[m_head]];
            ns   = tab_ns[sidx(m_state)][m_tape[m_head]];
            mv   = tab_mv[sidx(m_state)][m_tape[m_head]];
            if (ns == 0) begin
                m_tape[m_head] = nsym; m_cnt++; break;
            end
            if ($countones(ns) != 1) begin
                m_flt = 3; break;
            end
            m_tape[m_head] = nsym; m_state = ns; m_cnt++;
            if (!mv && m_head == 0)      begin m_flt = 1; break; end
            if (mv && m_head == TL - 1)  begin m_flt = 2; break; end
            m_head = mv ? m_head + 1 : m_head - 1;
            if (m_cnt == MS) begin m_to = 1; break; end
        end
    endtask

    task automatic run(input string tag, input bit disturb, input bit ld_start);
        int         cyc;
        logic [2:0] s;
        int         a;
        if (ld_start) begin
            a = $urandom_range(0, TL - 1);
            s = 3'($urandom_range(0, 7));
            tape_m[a] = s;
            load_en = 1'b1; load_addr = AW'(a); load_sym = s;
        end
        model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        check({tag, "_busy"}, 32'(busy), 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3 * MS + 6) begin
            if (disturb && cyc == 1) begin
                load_en = 1'b1; load_addr = AW'($urandom_range(0, TL - 1));
                load_sym = 3'($urandom_range(0, 7)); start = 1'b1;
            end
            @(posedge clk); #1;
            load_en = 1'b0; start = 1'b0;
            cyc++;
        end
        last_cycles = cyc;
        check({tag, "_cycles"}, 32'(cyc), 32'(3 * m_act));
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_end"}, 32'(busy), 0);
        check({tag, "_fault"}, 32'(fault), 32'(m_flt));
        check({tag, "_timeout"}, 32'(timeout), 32'(m_to));
        check({tag, "_head"}, 32'(head_pos), 32'(m_head));
        check({tag, "_count"}, 32'(step_count), 32'(m_cnt));
        check({tag, "_state"}, 32'(rule_state), 32'(m_state));
        for (int i = 0; i < TL; i++) begin
            rd_addr = AW'(i); #1;
            check({tag, "_tape"}, 32'(rd_sym), 32'(m_tape[i]));
            tape_m[i] = m_tape[i];
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; load_en = 1'b0;
        load_addr = '0; load_sym = '0; rd_addr = '0;
        for (int i = 0; i < 8; i++) set_all(i, 3'd0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(rule_state), 0);
        check("rst_sym", 32'(rule_sym), 0);
        check("rst_head", 32'(head_pos), 0);
        check("rst_count", 32'(step_count), 0);
        check("rst_flags", {busy, done, fault, timeout}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two steps: write 5 and move right, then halt.
        for (int i = 0; i < TL; i++) tape_m[i] = 3'd0;
        load_tape();
        set_all(0, 3'd5, 8'h02, 1'b1);
        set_all(1, 3'd5, 8'h00, 1'b1);
        run("t1", 1'b0, 1'b0);
        check("t1_cycles_abs", 32'(last_cycles), 6);
        check("t1_count_abs", 32'(step_count), 2);
        check("t1_head_abs", 32'(head_pos), 1);

        // Left edge fault on the first step.
        set_all(0, 3'd3, 8'h04, 1'b0);
        run("t2", 1'b0, 1'b0);
        check("t2_fault_abs", 32'(fault), 1);
        check("t2_count_abs", 32'(step_count), 1);

        // Illegal next state leaves tape and state alone.
        set_all(0, 3'd6, 8'h03, 1'b1);
        run("t3", 1'b0, 1'b0);
        check("t3_fault_abs", 32'(fault), 3);
        check("t3_count_abs", 32'(step_count), 0);

        // Alternating head driven by tape contents until the step limit.
        for (int i = 0; i < TL; i++) tape_m[i] = 3'd0;
        tape_m[1] = 3'd1;
        load_tape();
        for (int j = 0; j < 8; j++) begin
            tab_nsym[0][j] = 3'(j); tab_ns[0][j] = 8'h01; tab_mv[0][j] = (j == 0);
        end
        run("t4", 1'b0, 1'b0);
        check("t4_timeout_abs", 32'(timeout), 1);
        check("t4_cycles_abs", 32'(last_cycles), 24);

        // Right edge reached exactly on the last allowed step: fault wins over timeout.
        set_all(0, 3'd7, 8'h01, 1'b1);
        run("tr", 1'b0, 1'b0);
        check("tr_fault_abs", 32'(fault), 2);
        check("tr_timeout_abs", 32'(timeout), 0);

        // Reset during EVAL of step 3.
        for (int i = 0; i < TL; i++) tape_m[i] = 3'd0;
        load_tape();
        set_all(0, 3'd6, 8'h01, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("t5_busy_pre", 32'(busy), 1);
        rst_n = 1'b0; #1;
        check("t5_state", 32'(rule_state), 0);
        check("t5_sym", 32'(rule_sym), 0);
        check("t5_head", 32'(head_pos), 0);
        check("t5_count", 32'(step_count), 0);
        check("t5_flags", {busy, done, fault, timeout}, 0);
        rd_addr = 0; #1; check("t5_tape0", 32'(rd_sym), 6);
        rd_addr = 1; #1; check("t5_tape1", 32'(rd_sym), 6);
        rd_addr = 2; #1; check("t5_tape2", 32'(rd_sym), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tape_m[0] = 3'd6; tape_m[1] = 3'd6;
        @(posedge clk); #1;

        // Load and start pulses mid-run are ignored; a load in DONE lands.
        randomize_tables();
        run("t6", 1'b1, 1'b0);
        load_cell(5, ~tape_m[5]);
        tape_m[5] = ~tape_m[5];
        rd_addr = 5; #1;
        check("t6_done_load", 32'(rd_sym), 32'(tape_m[5]));

        for (int r = 0; r < 40; r++) begin
            randomize_tables();
            if (r % 3 == 0) begin
                for (int i = 0; i < TL; i++) tape_m[i] = 3'($urandom_range(0, 7));
                load_tape();
            end
            run("rnd", r[0], r % 4 == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/utm_step_controller.md
Name: utm_step_controller

Overview:
- Sequences one Turing-machine step at a time around the external combinational rule blocks: new-symbol, next-state and move-direction.
- Owns the tape storage, head position, one-hot machine state, step counter, and halt/fault detection.
- Sits between the host load/readback interface and the rule logic; the rule blocks stay purely combinational.

Parameters:
- TAPE_LEN, 32, number of tape cells, each 3 bits wide.
- ADDR_W, 5, head/address width; must satisfy 2**ADDR_W >= TAPE_LEN.
- START_HEAD, 0, head position loaded on each start.
- INIT_STATE, 8'b0000_0001, one-hot machine state loaded on each start.
- MAX_STEPS, 1023, step limit before timeout.
- CNT_W, 10, step counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- load_en  input  1  writes load_sym into tape[load_addr]; honoured only when busy=0.
- load_addr  input  ADDR_W  tape write address.
- load_sym  input  3  tape write data.
- rd_addr  input  ADDR_W  tape readback address.
- rd_sym  output  3  tape[rd_addr], combinational read.
- rule_state  output  8  registered one-hot state driven to the rule blocks.
- rule_sym  output  3  registered symbol under the head, driven to the rule blocks.
- rule_new_sym  input  3  new symbol from the rule blocks.
- rule_next_state  input  8  next one-hot state; all-zero means halt.
- rule_move_right  input  1  1 = move head right, 0 = move head left.
- busy  output  1  high while in READ, EVAL or WRITE.
- done  output  1  high in DONE.
- fault  output  2  0 none, 1 left edge, 2 right edge, 3 illegal state.
- timeout  output  1  run ended because MAX_STEPS was reached.
- head_pos  output  ADDR_W  current head position.
- step_count  output  CNT_W  number of completed steps.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE.
  - rule_state=0, rule_sym=0, head_pos=0, step_count=0.
  - busy=0, done=0, fault=0, timeout=0.
  - Tape cells are NOT reset; contents are undefined until loaded.
- FSM states: IDLE, READ, EVAL, WRITE, DONE.
- IDLE/DONE + start:
  - head_pos<=START_HEAD, rule_state<=INIT_STATE, step_count<=0.
  - fault<=0, timeout<=0, done<=0.
  - Go to READ.
- READ (1 cycle): rule_sym<=tape[head_pos]; go to EVAL.
- EVAL (1 cycle): rule ports settle from the registered rule_state and rule_sym; the controller samples rule_* at the end of this cycle into internal regs ns, nsym, mv.
- WRITE (1 cycle). Action is chosen in this priority order:
  1. ns==0 (halt): tape[head]<=nsym, step_count+1, go to DONE, fault=0.
  2. ns not one-hot: no tape write, fault<=3, go to DONE.
  3. mv=0 and head==0: tape[head]<=nsym, state<=ns, step_count+1, fault<=1, go to DONE.
  4. mv=1 and head==TAPE_LEN-1: same as case 3, but fault<=2.
  5. Otherwise: tape write, state<=ns, head+/-1, step_count+1. If the new step_count==MAX_STEPS, set timeout<=1 and go to DONE; else go to READ.
- Throughput: exactly 3 cycles per step.
- The head never wraps.
- step_count saturates; it cannot exceed MAX_STEPS.
- start while busy: ignored.
- load_en while busy: ignored, tape unchanged.
- load_en and start in the same cycle from IDLE: the load is performed first, and the run starts with the updated tape.
- rd_sym is valid in every state; reading while busy returns the current contents.
- Reset asserted mid-run: immediate return to IDLE; the tape holds whatever was written so far.
- done stays high until the next start or reset.

Decomposition:
- Shared package utm_pkg:
  - FSM state encoding.
  - Fault code constants: FLT_NONE, FLT_LEFT, FLT_RIGHT, FLT_STATE.
  - SYM_W=3 and STATE_W=8.
  - One-hot check function.
- Sub-module utm_tape: TAPE_LEN x 3 register file with one synchronous write port (shared by load and step write, muxed by the controller) and two combinational read ports (head, rd_addr).

Test Plan:
1. Load the tape with all 0, INIT_STATE=8'h01; rules return nsym=3'b101, ns=8'h02, right; then ns=0 on the next step -> done after 6 cycles, step_count=2, tape[0]=5, tape[1]=5, head_pos=1, fault=0.
2. START_HEAD=0, rules return move-left with ns=8'h04 -> done, fault=1, tape[0] written, head_pos=0, step_count=1.
3. Rules return ns=8'h03 -> fault=3, tape unchanged, rule_state unchanged, step_count=0.
4. Rules always return ns=8'h01, move alternating right/left, with MAX_STEPS=8 -> timeout=1 and step_count=8 after 24 cycles.
5. Assert rst_n low during EVAL of step 3 -> all outputs return to their reset values in the same cycle; rd_addr readback still shows the steps 1-2 writes.
6. Pulse load_en and start during a run -> tape and run are unaffected; the same load_en while in DONE updates the cell.
